tipi_msg_regs: RTL and testbench
================================

# tipi_msg_regs

Clocked, parametrised message-register exchange between the TI-99/4A memory bus and the Raspberry Pi serial register port. It provides NCHAN TI-to-RPi registers (TI writes, RPi shifts out) and NCHAN RPi-to-TI registers (RPi shifts in, TI reads). It replaces the fixed four-latch, asynchronous-clock register set with synchronised, edge-detected logic running on the board clock. It sits below the top level, beside the CRU bits and the DSR ROM, and drives the TI data-bus transmitter enable for its own address window.

## Interface
- NCHAN, 2, number of channel pairs (1..8)
- DATA_W, 8, register width; must equal the TI data-bus width (8)
- TOP_ADDR, 16'h5FFF, address of T register 0
- SYNC_STAGES, 2, synchroniser depth for all asynchronous inputs (2..3)
- SEL_W, 4, width of rpi_regsel; 2^SEL_W >= 2*NCHAN

- clk  in  1  board clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- dsr_en  in  1  CRU DSR-enable bit
- ti_a  in  16 [0:15]  TI address; bit 0 is MSB
- ti_data  in  8 [0:7]  TI write data
- ti_memen  in  1  active low
- ti_we  in  1  active low
- ti_dbin  in  1  active high read
- dsr_d  out  8 [0:7]  read data to the bus transmitter
- reg_oe_n  out  1  active-low transmitter enable for this window
- rpi_sclk  in  1  RPi shift clock
- rpi_sle  in  1  RPi latch/load strobe
- rpi_regsel  in  SEL_W  register select
- rpi_sdata_out  in  1  serial data, RPi to block
- rpi_sdata_in  out  1  serial data, block to RPi
- rpi_irq  out  1  pending-T-data notification (see Configuration)

## Operation
- Address map (odd addresses only):
  - T[k] at TOP_ADDR − 2k.
  - R[k] at TOP_ADDR − 2·NCHAN − 2k.
  - With the defaults this gives T0=5FFF, T1=5FFD, R0=5FFB, R1=5FF9.
- TI write:
  - wr_hit = dsr_en & ~ti_we & ~ti_memen & (ti_a == T[k] address).
  - wr_hit is synchronised through SYNC_STAGES flops.
  - On its synchronised rising edge, T[k] ← ti_data. ti_data is sampled directly because it is stable for the whole strobe.
- TI read:
  - rd_hit = dsr_en & ~ti_memen & ti_dbin & (ti_a == R[k] address). It is combinational.
  - While rd_hit: reg_oe_n = 0 and dsr_d = R[k]. Otherwise reg_oe_n = 1 and dsr_d = all Z.
- RPi port:
  - rpi_sclk, rpi_sle, rpi_regsel and rpi_sdata_out are synchronised, and rising edges of sclk and sle are detected.
  - Select values 0..NCHAN−1 address R shadow k. Values NCHAN..2·NCHAN−1 address T channel (sel − NCHAN). Values ≥ 2·NCHAN are ignored.
- R path:
  - On an sclk edge, shadow[k] ← {shadow[k][1:7], rpi_sdata_out}, MSB first.
  - On an sle edge, R[k] ← shadow[k].
- T path:
  - On an sle edge, out_sr ← T[k].
  - On each later sclk edge, out_sr shifts left with 0 fill.
  - rpi_sdata_in = out_sr[0] at all times.
- Read-stability rule: if an R[k] update falls due while the synchronised rd_hit for R[k] is high, the update is held pending. It commits on the first cycle after the read ends. A second sle edge while pending overwrites the pending value (last wins).

## Timing
- Reset values:
  - All T, R, shadow and out_sr registers are 0.
  - Pending flags are cleared.
  - rpi_sdata_in = 0, reg_oe_n = 1, dsr_d = Z, rpi_irq = 0.
- TI write latency: T[k] holds the new value SYNC_STAGES+1 clk after wr_hit rises. The minimum strobe width is SYNC_STAGES+2 clk.
- RPi shift latency: a bit is in shadow SYNC_STAGES+1 clk after its sclk rising edge. The minimum sclk high and low time is SYNC_STAGES+1 clk each.
- Simultaneous sle and sclk edges in the same cycle: the latch/load happens and no shift occurs.
- regsel is sampled on the same synchronised cycle as the edge that uses it.
- A TI write and an RPi load of the same T[k] in the same cycle: the load takes the old value, and T[k] updates afterwards.
- Reset mid-shift or mid-write aborts the operation immediately. No partial commit survives.
- Read output is combinational. reg_oe_n follows rd_hit with no clock delay.

## Configuration
- TIPI_NOTIFY_EN defined:
  - Per-channel sticky flag dirty[k] is set on each TI write to T[k].
  - dirty[k] is cleared on an RPi sle load of T[k].
  - If the write and the load occur in the same cycle, set wins.
  - rpi_irq = OR of dirty[]. It is registered and changes one clk after the flag change.
- Undefined: no dirty flags are implemented and rpi_irq is tied 0.

## Test plan
- Reset, then a TI write of 0xA5 to 5FFF with dsr_en=1 → T0=0xA5 after 3 clk. With regsel=2, an sle edge followed by 8 sclk edges → rpi_sdata_in sequence 1,0,1,0,0,1,0,1.
- With dsr_en=0, a write of 0xFF to 5FFD → T1 stays 0x00 and reg_oe_n stays 1.
- With regsel=0, shift in 0x3C and pulse sle → a TI read at 5FFB gives dsr_d=0x3C and reg_oe_n=0. A read at 5FFA gives reg_oe_n=1 and dsr_d=Z.
- Hold a TI read of 5FF9 active while the RPi latches 0x81 into R1 → dsr_d stays at the old 0x00 until dbin falls, then a re-read returns 0x81.
- With regsel=5 (out of range), 8 sclk edges and an sle edge → no register changes. Assert rst mid-shift → all registers read 0x00.
- TIPI_NOTIFY_EN defined: a TI write to 5FFD → rpi_irq=1. An RPi load with regsel=3 → rpi_irq=0 one clk later. The same bench with the macro undefined → rpi_irq=0 throughout.

Source files
------------

// File: rtl/tipi_msg_regs.sv
// rtl/tipi_msg_regs.sv - TI-99/4A <-> Raspberry Pi message register exchange
//
// Purpose: NCHAN TI-to-RPi registers (T, written by the TI, shifted out by the
// RPi) and NCHAN RPi-to-TI registers (R, shifted in by the RPi, read by the TI).
// All asynchronous inputs are synchronised to clk and edge-detected.
//
// Optional feature macro: TIPI_NOTIFY_EN
//   defined   - per-channel dirty flags, rpi_irq = registered OR of dirty[]
//   undefined - no dirty flags, rpi_irq tied 0
//
// Ports:
//   clk, rst           board clock, asynchronous active-high reset
//   dsr_en             CRU DSR-enable bit
//   ti_a, ti_data      TI address / write data (bit 0 is MSB)
//   ti_memen, ti_we    active-low memory enable / write strobe
//   ti_dbin            active-high read strobe
//   dsr_d, reg_oe_n    read data (Z when idle) / active-low transmitter enable
//   rpi_sclk, rpi_sle  RPi shift clock / latch-load strobe
//   rpi_regsel         RPi register select
//   rpi_sdata_out      serial data RPi -> block
//   rpi_sdata_in       serial data block -> RPi (MSB of out shift register)
//   rpi_irq            pending T-data notification
module tipi_msg_regs #(
    parameter int          NCHAN       = 2,
    parameter int          DATA_W      = 8,
    parameter logic [15:0] TOP_ADDR    = 16'h5FFF,
    parameter int          SYNC_STAGES = 2,
    parameter int          SEL_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dsr_en,
    input  logic [0:15]       ti_a,
    input  logic [0:DATA_W-1] ti_data,
    input  logic              ti_memen,
    input  logic              ti_we,
    input  logic              ti_dbin,
    output logic [0:DATA_W-1] dsr_d,
    output logic              reg_oe_n,
    input  logic              rpi_sclk,
    input  logic              rpi_sle,
    input  logic [SEL_W-1:0]  rpi_regsel,
    input  logic              rpi_sdata_out,
    output logic              rpi_sdata_in,
    output logic              rpi_irq
);

    localparam int RW = SEL_W + 3;

    logic [NCHAN-1:0]  w_wr_hit;
    logic [NCHAN-1:0]  w_rd_hit;
    logic [NCHAN-1:0]  w_wr_rise;
    logic [NCHAN-1:0]  r_wr_sync [SYNC_STAGES];
    logic [NCHAN-1:0]  r_wr_prev;
    logic [NCHAN-1:0]  r_rd_sync [SYNC_STAGES];
    logic [RW-1:0]     r_rpi_sync [SYNC_STAGES];
    logic              r_sclk_prev;
    logic              r_sle_prev;

    logic [0:DATA_W-1] r_t      [NCHAN];
    logic [0:DATA_W-1] r_r      [NCHAN];
    logic [0:DATA_W-1] r_shadow [NCHAN];
    logic [0:DATA_W-1] r_pend_val [NCHAN];
    logic [NCHAN-1:0]  r_pend;
    logic [0:DATA_W-1] r_out_sr;

    logic              w_sclk_s;
    logic              w_sle_s;
    logic              w_sdata_s;
    logic [SEL_W-1:0]  w_sel;
    logic              w_sclk_rise;
    logic              w_sle_rise;
    logic              w_sel_t;
    logic [0:DATA_W-1] w_t_sel_val;
    logic              w_rd_any;
    logic [0:DATA_W-1] w_rd_data;
    logic [NCHAN-1:0]  w_rd_busy;

    // Address decode: T[k] at TOP_ADDR-2k, R[k] below the T block.
    always_comb begin
        w_wr_hit = '0;
        w_rd_hit = '0;
        for (int k = 0; k < NCHAN; k++) begin
            w_wr_hit[k] = dsr_en & ~ti_we & ~ti_memen &
                          (ti_a == 16'(TOP_ADDR - 16'(2 * k)));
            w_rd_hit[k] = dsr_en & ~ti_memen & ti_dbin &
                          (ti_a == 16'(TOP_ADDR - 16'(2 * NCHAN + 2 * k)));
        end
    end

    assign {w_sclk_s, w_sle_s, w_sdata_s, w_sel} = r_rpi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sle_rise  = w_sle_s  & ~r_sle_prev;
    assign w_wr_rise   = r_wr_sync[SYNC_STAGES-1] & ~r_wr_prev;
    assign w_rd_busy   = r_rd_sync[SYNC_STAGES-1];

    // T-side select decode; selects >= 2*NCHAN match nothing and are ignored.
    always_comb begin
        w_sel_t     = 1'b0;
        w_t_sel_val = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (int'(w_sel) == k + NCHAN) begin
                w_sel_t     = 1'b1;
                w_t_sel_val = r_t[k];
            end
        end
    end

    // Synchronisers and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_wr_sync[s]  <= '0;
                r_rd_sync[s]  <= '0;
                r_rpi_sync[s] <= '0;
            end
            r_wr_prev   <= '0;
            r_sclk_prev <= 1'b0;
            r_sle_prev  <= 1'b0;
        end else begin
            r_wr_sync[0]  <= w_wr_hit;
            r_rd_sync[0]  <= w_rd_hit;
            r_rpi_sync[0] <= {rpi_sclk, rpi_sle, rpi_sdata_out, rpi_regsel};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_wr_sync[s]  <= r_wr_sync[s-1];
                r_rd_sync[s]  <= r_rd_sync[s-1];
                r_rpi_sync[s] <= r_rpi_sync[s-1];
            end
            r_wr_prev   <= r_wr_sync[SYNC_STAGES-1];
            r_sclk_prev <= w_sclk_s;
            r_sle_prev  <= w_sle_s;
        end
    end

    // Register file. An sle edge takes priority over a coincident sclk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCHAN; k++) begin
                r_t[k]        <= '0;
                r_r[k]        <= '0;
                r_shadow[k]   <= '0;
                r_pend_val[k] <= '0;
            end
            r_pend   <= '0;
            r_out_sr <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                // ti_data is stable for the whole strobe, so it is sampled raw.
                if (w_wr_rise[k]) begin
                    r_t[k] <= ti_data;
                end

                if (w_sle_rise && int'(w_sel) == k) begin
                    // While the TI is reading R[k], park the update; last wins.
                    if (w_rd_busy[k]) begin
                        r_pend[k]     <= 1'b1;
                        r_pend_val[k] <= r_shadow[k];
                    end else begin
                        r_r[k]    <= r_shadow[k];
                        r_pend[k] <= 1'b0;
                    end
                end else if (r_pend[k] && !w_rd_busy[k]) begin
                    r_r[k]    <= r_pend_val[k];
                    r_pend[k] <= 1'b0;
                end

                if (w_sclk_rise && !w_sle_rise && int'(w_sel) == k) begin
                    r_shadow[k] <= {r_shadow[k][1:DATA_W-1], w_sdata_s};
                end
            end

            // Non-blocking read of r_t gives the pre-write value on a same-cycle
            // TI write and RPi load.
            if (w_sle_rise && w_sel_t) begin
                r_out_sr <= w_t_sel_val;
            end else if (w_sclk_rise && w_sel_t) begin
                r_out_sr <= {r_out_sr[1:DATA_W-1], 1'b0};
            end
        end
    end

    assign rpi_sdata_in = r_out_sr[0];

`ifdef TIPI_NOTIFY_EN
    logic [NCHAN-1:0] r_dirty;
    logic             r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dirty <= '0;
            r_irq   <= 1'b0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (w_wr_rise[k]) begin
                    r_dirty[k] <= 1'b1;
                end else if (w_sle_rise && int'(w_sel) == k + NCHAN) begin
                    r_dirty[k] <= 1'b0;
                end
            end
            r_irq <= |r_dirty;
        end
    end

    assign rpi_irq = r_irq;
`else
    assign rpi_irq = 1'b0;
`endif

    // TI read path is purely combinational.
    always_comb begin
        w_rd_any  = 1'b0;
        w_rd_data = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (w_rd_hit[k]) begin
                w_rd_any  = 1'b1;
                w_rd_data = r_r[k];
            end
        end
    end

    assign reg_oe_n = ~w_rd_any;
    assign dsr_d    = w_rd_any ? w_rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_tipi_msg_regs.sv
// tb/tb_tipi_msg_regs.sv - directed-vector bench for tipi_msg_regs
module tb_tipi_msg_regs;

`ifdef TIPI_NOTIFY_EN
    localparam logic NOTIFY = 1'b1;
`else
    localparam logic NOTIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dsr_en = 1'b0;
    logic [0:15] ti_a = 16'h0000;
    logic [0:7]  ti_data = 8'h00;
    logic        ti_memen = 1'b1;
    logic        ti_we = 1'b1;
    logic        ti_dbin = 1'b0;
    wire  [0:7]  dsr_d;
    wire         reg_oe_n;
    logic        rpi_sclk = 1'b0;
    logic        rpi_sle = 1'b0;
    logic [3:0]  rpi_regsel = 4'd0;
    logic        rpi_sdata_out = 1'b0;
    wire         rpi_sdata_in;
    wire         rpi_irq;

    int n_vec  = 0;
    int n_miss = 0;

    tipi_msg_regs dut (
        .clk           (clk),
        .rst           (rst),
        .dsr_en        (dsr_en),
        .ti_a          (ti_a),
        .ti_data       (ti_data),
        .ti_memen      (ti_memen),
        .ti_we         (ti_we),
        .ti_dbin       (ti_dbin),
        .dsr_d         (dsr_d),
        .reg_oe_n      (reg_oe_n),
        .rpi_sclk      (rpi_sclk),
        .rpi_sle       (rpi_sle),
        .rpi_regsel    (rpi_regsel),
        .rpi_sdata_out (rpi_sdata_out),
        .rpi_sdata_in  (rpi_sdata_in),
        .rpi_irq       (rpi_irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ti_write(input logic [15:0] a, input logic [7:0] d, input logic en);
        dsr_en = en; ti_a = a; ti_data = d; ti_memen = 1'b0; ti_we = 1'b0;
        cyc(5);
        ti_we = 1'b1; ti_memen = 1'b1;
        cyc(2);
    endtask

    task automatic ti_rd_on(input logic [15:0] a);
        dsr_en = 1'b1; ti_a = a; ti_memen = 1'b0; ti_dbin = 1'b1;
        #1;
    endtask

    task automatic ti_rd_off;
        ti_dbin = 1'b0; ti_memen = 1'b1;
        #1;
    endtask

    task automatic sclk_pulse;
        rpi_sclk = 1'b1; cyc(4);
        rpi_sclk = 1'b0; cyc(4);
    endtask

    task automatic sle_pulse(input logic [3:0] sel);
        rpi_regsel = sel; cyc(1);
        rpi_sle = 1'b1; cyc(4);
        rpi_sle = 1'b0; cyc(4);
    endtask

    task automatic shift_in(input logic [3:0] sel, input logic [7:0] b);
        rpi_regsel = sel;
        for (int i = 7; i >= 0; i--) begin
            rpi_sdata_out = b[i];
            cyc(1);
            sclk_pulse();
        end
    endtask

    // Collects the 8 bits presented after a load (MSB first).
    task automatic read_out(output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            got = {got[6:0], rpi_sdata_in};
            if (i < 7) sclk_pulse();
        end
    endtask

    task automatic shift_out(input logic [3:0] sel, output logic [7:0] got);
        sle_pulse(sel);
        read_out(got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_a5;
        logic [7:0] got;
        exp_a5 = 8'hA5;

        cyc(3);
        chk("rst_oe_n", reg_oe_n, 1'b1);
        chk("rst_sdin", rpi_sdata_in, 1'b0);
        chk("rst_irq", rpi_irq, 1'b0);
        rst = 1'b0;
        cyc(2);
        ti_rd_on(16'h5FFB);
        chk("rst_r0", dsr_d, 8'h00);
        ti_rd_off();

        // TI write 0xA5 to T0, then shift out with regsel=2
        ti_write(16'h5FFF, 8'hA5, 1'b1);
        chk("t0_irq_set", rpi_irq, NOTIFY);
        sle_pulse(4'd2);
        chk("t0_irq_clr", rpi_irq, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t0_bit%0d", i), rpi_sdata_in, exp_a5[7-i]);
            sclk_pulse();
        end
        chk("t0_drained", rpi_sdata_in, 1'b0);

        // write with dsr_en=0 is ignored
        ti_write(16'h5FFD, 8'hFF, 1'b0);
        chk("t1_noen_irq", rpi_irq, 1'b0);
        shift_out(4'd3, got);
        chk("t1_noen_val", got, 8'h00);

        // write 0x5A to T1: latency 3 clk, irq one clk after dirty
        dsr_en = 1'b1; ti_a = 16'h5FFD; ti_data = 8'h5A; ti_memen = 1'b0; ti_we = 1'b0;
        cyc(3);
        chk("t1_irq_early", rpi_irq, 1'b0);
        cyc(1);
        chk("t1_irq_set", rpi_irq, NOTIFY);
        cyc(1);
        ti_we = 1'b1; ti_memen = 1'b1;
        cyc(2);
        rpi_regsel = 4'd3; cyc(1);
        rpi_sle = 1'b1;
        cyc(3);
        chk("t1_irq_hold", rpi_irq, NOTIFY);
        cyc(1);
        chk("t1_irq_clr", rpi_irq, 1'b0);
        rpi_sle = 1'b0; cyc(4);
        read_out(got);
        chk("t1_val", got, 8'h5A);

        // shift 0x3C into R0 and read it
        shift_in(4'd0, 8'h3C);
        sle_pulse(4'd0);
        ti_rd_on(16'h5FFB);
        chk("r0_data", dsr_d, 8'h3C);
        chk("r0_oe_n", reg_oe_n, 1'b0);
        ti_rd_off();
        ti_rd_on(16'h5FFA);
        chk("even_oe_n", reg_oe_n, 1'b1);
        ti_rd_off();
        chk("idle_oe_n", reg_oe_n, 1'b1);

        // read-stability: R1 update parked during an active read
        ti_rd_on(16'h5FF9);
        cyc(4);
        shift_in(4'd1, 8'h81);
        sle_pulse(4'd1);
        chk("r1_held", dsr_d, 8'h00);
        chk("r1_held_oe", reg_oe_n, 1'b0);
        ti_rd_off();
        cyc(6);
        ti_rd_on(16'h5FF9);
        chk("r1_commit", dsr_d, 8'h81);
        ti_rd_off();

        // out-of-range select changes nothing
        rpi_regsel = 4'd5;
        rpi_sdata_out = 1'b1;
        for (int i = 0; i < 8; i++) sclk_pulse();
        sle_pulse(4'd5);
        ti_rd_on(16'h5FFB);
        chk("oor_r0", dsr_d, 8'h3C);
        ti_rd_off();
        ti_rd_on(16'h5FF9);
        chk("oor_r1", dsr_d, 8'h81);
        ti_rd_off();
        sle_pulse(4'd0);
        ti_rd_on(16'h5FFB);
        chk("oor_shadow0", dsr_d, 8'h3C);
        ti_rd_off();
        shift_out(4'd2, got);
        chk("oor_t0", got, 8'hA5);

        // reset mid-shift clears everything
        sle_pulse(4'd2);
        chk("pre_rst_sdin", rpi_sdata_in, 1'b1);
        rpi_regsel = 4'd0; rpi_sdata_out = 1'b1;
        rpi_sclk = 1'b1;
        cyc(1);
        rst = 1'b1;
        #1;
        chk("rst_async_sdin", rpi_sdata_in, 1'b0);
        cyc(2);
        rpi_sclk = 1'b0;
        rst = 1'b0;
        cyc(4);
        ti_rd_on(16'h5FFB);
        chk("rst2_r0", dsr_d, 8'h00);
        ti_rd_off();
        ti_rd_on(16'h5FF9);
        chk("rst2_r1", dsr_d, 8'h00);
        ti_rd_off();
        chk("rst2_irq", rpi_irq, 1'b0);
        shift_out(4'd2, got);
        chk("rst2_t0", got, 8'h00);
        shift_out(4'd3, got);
        chk("rst2_t1", got, 8'h00);
        sle_pulse(4'd0);
        ti_rd_on(16'h5FFB);
        chk("rst2_shadow0", dsr_d, 8'h00);
        ti_rd_off();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
